// File: rtl/audio_mem_pkg.sv
// Shared definitions for the audio record/playback path.
//   - seq_state_e : sequencer state encoding
//   - MODE_*      : encodings of the externally visible `mode` output
//   - ADDR_W_DEF / DATA_W_DEF : default SRAM geometry, shared with the SRAM controller
package audio_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_REC  = 2'd1;
  localparam logic [1:0] MODE_PLAY = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StRecWait,
    StRecWr,
    StPlayWait,
    StPlayRd
  } seq_state_e;

endpackage

// File: rtl/access_timer.sv
// Access-length timer for SRAM requests.
// Loaded with ACCESS_CYCLES-1 on `start`, counts down to zero and holds there.
// `last` is high while the count is zero, i.e. in the final cycle of an access
// that began on the cycle after `start`.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   start  in  load the counter (first access cycle follows)
//   last   out current access cycle is the final one
module access_timer #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic last
);

  localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CntW-1:0] Load = CntW'(ACCESS_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= Load;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/audio_mem_seq.sv
// Record/playback sequencer driving the request side of the SRAM controller.
// Record: each ADC sample is written to consecutive words from address 0.
// Play:   one word is read per DAC request, in order, up to the recorded length.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   cmd_record/play/stop    one-cycle command pulses (priority stop > record > play)
//   adc_valid, adc_data     sample strobe and data to record
//   dac_req                 codec asks for the next playback sample
//   dac_data, dac_valid     playback sample (held) and its one-cycle update pulse
//   mem_addr/read/write     SRAM request (read/write are levels held ACCESS_CYCLES)
//   mem_wdata, mem_rdata    SRAM write data out, combinational read data in
//   mode                    0 idle, 1 record, 2 play
//   rec_len                 words recorded (saturates at 2^ADDR_W-1)
//   overrun                 sticky: strobe dropped during an access
//   done                    one-cycle pulse when record/play ends on its own
module audio_mem_seq
  import audio_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_record,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              dac_req,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] rec_len,
  output logic              overrun,
  output logic              done
);

  localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};

  seq_state_e        state_q;
  logic              stop_pend_q;  // stop seen mid-access, applied when it completes
  logic              rec_start;
  logic              play_start;
  logic              acc_start;
  logic              acc_last;
  logic [ADDR_W-1:0] addr_inc;

  // Access starts; stop in the same cycle wins over the strobe.
  assign rec_start  = (state_q == StRecWait) && adc_valid && !cmd_stop;
  assign play_start = (state_q == StPlayWait) && dac_req && !cmd_stop;
  assign acc_start  = rec_start || play_start;
  assign addr_inc   = mem_addr + 1'b1;

  access_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .start(acc_start),
    .last (acc_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      stop_pend_q <= 1'b0;
      dac_data    <= '0;
      dac_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
      mode        <= MODE_IDLE;
      rec_len     <= '0;
      overrun     <= 1'b0;
      done        <= 1'b0;
    end else begin
      dac_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_stop) begin
            // Nothing to stop; also masks record/play in the same cycle.
          end else if (cmd_record) begin
            mem_addr <= '0;
            rec_len  <= '0;
            overrun  <= 1'b0;
            state_q  <= StRecWait;
            mode     <= MODE_REC;
          end else if (cmd_play && (rec_len != '0)) begin
            mem_addr <= '0;
            state_q  <= StPlayWait;
            mode     <= MODE_PLAY;
          end
        end

        StRecWait: begin
          if (cmd_stop) begin
            state_q <= StIdle;
            mode    <= MODE_IDLE;
          end else if (rec_start) begin
            mem_wdata <= adc_data;
            mem_write <= 1'b1;
            state_q   <= StRecWr;
          end
        end

        StRecWr: begin
          if (adc_valid) overrun <= 1'b1;
          if (cmd_stop) stop_pend_q <= 1'b1;
          if (acc_last) begin
            mem_write   <= 1'b0;
            mem_addr    <= addr_inc;
            stop_pend_q <= 1'b0;
            if (mem_addr == AddrMax) begin
              // Memory full: rec_len already holds AddrMax from the previous word.
              done    <= 1'b1;
              state_q <= StIdle;
              mode    <= MODE_IDLE;
            end else begin
              rec_len <= addr_inc;
              if (stop_pend_q || cmd_stop) begin
                state_q <= StIdle;
                mode    <= MODE_IDLE;
              end else begin
                state_q <= StRecWait;
              end
            end
          end
        end

        StPlayWait: begin
          if (cmd_stop) begin
            state_q <= StIdle;
            mode    <= MODE_IDLE;
          end else if (play_start) begin
            mem_read <= 1'b1;
            state_q  <= StPlayRd;
          end
        end

        StPlayRd: begin
          if (dac_req) overrun <= 1'b1;
          if (cmd_stop) stop_pend_q <= 1'b1;
          if (acc_last) begin
            mem_read    <= 1'b0;
            dac_data    <= mem_rdata;
            dac_valid   <= 1'b1;
            mem_addr    <= addr_inc;
            stop_pend_q <= 1'b0;
            if (addr_inc == rec_len) begin
              done    <= 1'b1;
              state_q <= StIdle;
              mode    <= MODE_IDLE;
            end else if (stop_pend_q || cmd_stop) begin
              state_q <= StIdle;
              mode    <= MODE_IDLE;
            end else begin
              state_q <= StPlayWait;
            end
          end
        end

        default: begin
          state_q   <= StIdle;
          mode      <= MODE_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mem_seq.sv
// Directed bench for audio_mem_seq: record/play with a model SRAM, overrun,
// command priority, reset mid-access, and memory-full on a 3-bit-address instance.
module tb_audio_mem_seq;

  localparam int AC = 2;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    int          len;
    bit          stable;
  } wr_obs_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  typedef struct {
    logic [15:0] data;
    int          cyc;
    bit          done;
  } dac_obs_t;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } dac_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_record, cmd_play, cmd_stop, adc_valid, dac_req;
  logic [15:0] adc_data;
  logic [15:0] dac_data, mem_wdata, mem_rdata;
  logic        dac_valid, mem_read, mem_write, overrun, done;
  logic [17:0] mem_addr, rec_len;
  logic [1:0]  mode;

  logic        s_cmd_record, s_adc_valid;
  logic [15:0] s_adc_data;
  logic [15:0] s_dac_data, s_mem_wdata;
  logic        s_dac_valid, s_mem_read, s_mem_write, s_overrun, s_done;
  logic [2:0]  s_mem_addr, s_rec_len;
  logic [1:0]  s_mode;

  logic [15:0] sram [0:255];
  assign mem_rdata = sram[mem_addr[7:0]];

  audio_mem_seq u_dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_record(cmd_record),
    .cmd_play  (cmd_play),
    .cmd_stop  (cmd_stop),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .dac_req   (dac_req),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mode      (mode),
    .rec_len   (rec_len),
    .overrun   (overrun),
    .done      (done)
  );

  audio_mem_seq #(
    .ADDR_W(3)
  ) u_small (
    .clk       (clk),
    .reset     (reset),
    .cmd_record(s_cmd_record),
    .cmd_play  (1'b0),
    .cmd_stop  (1'b0),
    .adc_valid (s_adc_valid),
    .adc_data  (s_adc_data),
    .dac_req   (1'b0),
    .dac_data  (s_dac_data),
    .dac_valid (s_dac_valid),
    .mem_addr  (s_mem_addr),
    .mem_read  (s_mem_read),
    .mem_write (s_mem_write),
    .mem_wdata (s_mem_wdata),
    .mem_rdata (16'h0000),
    .mode      (s_mode),
    .rec_len   (s_rec_len),
    .overrun   (s_overrun),
    .done      (s_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-window monitor and model SRAM.
  wr_obs_t     obs_wr[$];
  int          wlen = 0;
  logic [17:0] waddr;
  logic [15:0] wdat;
  bit          wstable;
  int          both_high = 0;
  always @(negedge clk) begin
    if (mem_read && mem_write) both_high++;
    if (mem_write) begin
      if (wlen == 0) begin
        waddr   = mem_addr;
        wdat    = mem_wdata;
        wstable = 1'b1;
        sram[mem_addr[7:0]] = mem_wdata;
      end else if (mem_addr !== waddr || mem_wdata !== wdat) begin
        wstable = 1'b0;
      end
      wlen++;
    end else if (wlen != 0) begin
      obs_wr.push_back('{addr: waddr, data: wdat, len: wlen, stable: wstable});
      wlen = 0;
    end
  end

  dac_obs_t obs_dac[$];
  always @(negedge clk) begin
    if (dac_valid) obs_dac.push_back('{data: dac_data, cyc: cyc, done: done});
  end

  logic [2:0] s_addrs[$];
  bit         s_in_wr = 1'b0;
  int         s_done_cnt = 0;
  always @(negedge clk) begin
    if (s_done) s_done_cnt++;
    if (s_mem_write && !s_in_wr) s_addrs.push_back(s_mem_addr);
    s_in_wr = s_mem_write;
  end

  int vectors = 0;
  int miscompares = 0;
  wr_exp_t  exp_wr[$];
  dac_exp_t exp_dac[$];
  int wr_rd = 0;
  int dac_rd = 0;
  logic [15:0] rec_data [3] = '{16'h1111, 16'h2222, 16'h3333};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic cmp_next_wr(input string tag);
    wr_obs_t o;
    wr_exp_t e;
    check({tag, " window seen"}, 32'(obs_wr.size() > wr_rd), 1);
    if (obs_wr.size() > wr_rd && exp_wr.size() > 0) begin
      o = obs_wr[wr_rd];
      wr_rd++;
      e = exp_wr.pop_front();
      check({tag, " addr"}, 32'(o.addr), 32'(e.addr));
      check({tag, " wdata"}, 32'(o.data), 32'(e.data));
      check({tag, " write len"}, o.len, AC);
      check({tag, " addr/wdata stable"}, 32'(o.stable), 1);
    end
  endtask

  task automatic cmp_next_dac(input string tag, input bit want_done);
    dac_obs_t o;
    dac_exp_t e;
    check({tag, " dac_valid seen"}, 32'(obs_dac.size() > dac_rd), 1);
    if (obs_dac.size() > dac_rd && exp_dac.size() > 0) begin
      o = obs_dac[dac_rd];
      dac_rd++;
      e = exp_dac.pop_front();
      check({tag, " dac_data"}, 32'(o.data), 32'(e.data));
      check({tag, " latency"}, o.cyc - e.cyc, AC + 1);
      check({tag, " done"}, 32'(o.done), 32'(want_done));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    {cmd_record, cmd_play, cmd_stop, adc_valid, dac_req} = '0;
    adc_data = '0;
    {s_cmd_record, s_adc_valid} = '0;
    s_adc_data = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("reset ctl", 32'({mode, overrun, done, dac_valid, mem_read, mem_write}), 0);
    check("reset rec_len", 32'(rec_len), 0);
    check("reset dac_data", 32'(dac_data), 0);
    check("reset mem_addr", 32'(mem_addr), 0);

    // Record three samples, spacing 10.
    cmd_record = 1'b1; tick(1); cmd_record = 1'b0;
    check("mode rec", 32'(mode), 1);
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back('{addr: 18'(i), data: rec_data[i]});
      adc_data = rec_data[i];
      adc_valid = 1'b1; tick(1); adc_valid = 1'b0;
      tick(9);
      cmp_next_wr("rec");
    end
    check("rec_len 3", 32'(rec_len), 3);
    check("no overrun", 32'(overrun), 0);
    cmd_stop = 1'b1; tick(1); cmd_stop = 1'b0;
    check("mode idle after stop", 32'(mode), 0);

    // Playback against the model SRAM.
    cmd_play = 1'b1; tick(1); cmd_play = 1'b0;
    check("mode play", 32'(mode), 2);
    for (int i = 0; i < 3; i++) begin
      exp_dac.push_back('{data: rec_data[i], cyc: cyc});
      dac_req = 1'b1; tick(1); dac_req = 1'b0;
      tick(9);
      cmp_next_dac("play", i == 2);
    end
    check("mode idle after play", 32'(mode), 0);
    check("rec_len kept after play", 32'(rec_len), 3);

    // Second adc_valid during the write: dropped, overrun set.
    cmd_record = 1'b1; tick(1); cmd_record = 1'b0;
    check("rec_len cleared", 32'(rec_len), 0);
    exp_wr.push_back('{addr: 18'd0, data: 16'hAAAA});
    adc_data = 16'hAAAA; adc_valid = 1'b1; tick(1);
    adc_data = 16'hBBBB; tick(1);
    adc_valid = 1'b0;
    tick(8);
    cmp_next_wr("ovr");
    check("ovr single write", obs_wr.size() - wr_rd, 0);
    check("overrun set", 32'(overrun), 1);
    check("rec_len after ovr", 32'(rec_len), 1);
    cmd_stop = 1'b1; tick(1); cmd_stop = 1'b0;
    cmd_record = 1'b1; tick(1); cmd_record = 1'b0;
    check("overrun cleared", 32'(overrun), 0);

    // Stop beats record in PLAY_WAIT; rec_len untouched.
    exp_wr.push_back('{addr: 18'd0, data: 16'h4444});
    adc_data = 16'h4444; adc_valid = 1'b1; tick(1); adc_valid = 1'b0;
    tick(9);
    cmp_next_wr("one");
    cmd_stop = 1'b1; tick(1); cmd_stop = 1'b0;
    cmd_play = 1'b1; tick(1); cmd_play = 1'b0;
    check("mode play2", 32'(mode), 2);
    cmd_stop = 1'b1; cmd_record = 1'b1; tick(1);
    cmd_stop = 1'b0; cmd_record = 1'b0;
    check("stop>record mode", 32'(mode), 0);
    check("stop>record rec_len", 32'(rec_len), 1);

    // Play with nothing recorded is ignored.
    cmd_record = 1'b1; tick(1); cmd_record = 1'b0;
    cmd_stop = 1'b1; tick(1); cmd_stop = 1'b0;
    check("empty rec_len", 32'(rec_len), 0);
    cmd_play = 1'b1; tick(1); cmd_play = 1'b0;
    check("play empty ignored", 32'(mode), 0);
    check("play empty no read", 32'(mem_read), 0);

    // Reset in the first write cycle.
    cmd_record = 1'b1; tick(1); cmd_record = 1'b0;
    adc_data = 16'h5555; adc_valid = 1'b1; tick(1); adc_valid = 1'b0;
    check("write before reset", 32'(mem_write), 1);
    reset = 1'b1; tick(1);
    check("rst mem_write", 32'(mem_write), 0);
    check("rst ctl", 32'({mode, overrun, done, dac_valid, mem_read}), 0);
    check("rst rec_len", 32'(rec_len), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst dac_data", 32'(dac_data), 0);
    check("rst mem_wdata", 32'(mem_wdata), 0);
    reset = 1'b0;
    tick(2);
    check("rst partial len", (obs_wr.size() > wr_rd) ? obs_wr[wr_rd].len : -1, 1);
    wr_rd = obs_wr.size();

    // ADDR_W=3: nine samples, eight writes, then full.
    s_cmd_record = 1'b1; tick(1); s_cmd_record = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_adc_data = 16'(i + 1);
      s_adc_valid = 1'b1; tick(1); s_adc_valid = 1'b0;
      tick(9);
    end
    check("small write count", s_addrs.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("small addr", (k < s_addrs.size()) ? 32'(s_addrs[k]) : 32'hFFFF, k);
    end
    check("small done count", s_done_cnt, 1);
    check("small mode", 32'(s_mode), 0);
    check("small rec_len", 32'(s_rec_len), 7);
    check("small last wdata", 32'(s_mem_wdata), 8);
    check("small idle ctl", 32'({s_overrun, s_mem_read, s_dac_valid}), 0);
    check("small dac_data", 32'(s_dac_data), 0);

    check("read/write overlap", both_high, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
